// File: rtl/ar_mem_responder.sv
`default_nettype none
// ar_mem_responder: memory-side responder with fixed wait states and one-cycle ack.
// Revision 1.0
module ar_mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 16,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] din,
  output logic              busy,
  output logic              ack,
  output logic [DATA_W-1:0] dout
);

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
      $error("ar_mem_responder: LATENCY must be in the range 1..15");
    end
  endgenerate

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state;
  logic [3:0]          cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [DATA_W-1:0]   din_q;
  logic [DATA_W-1:0]   mem [0:(1<<ADDR_W)-1];
  logic                do_access;

  assign do_access = (state == S_WAIT) && (cnt == 4'd0);
  assign busy      = (state != S_IDLE);

  // Array has no reset; an async reset pulls state out of WAIT before any edge can write.
  always_ff @(posedge clk) begin
    if (do_access && we_q) begin
      mem[addr_q] <= din_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      addr_q <= '0;
      we_q   <= 1'b0;
      din_q  <= '0;
      ack    <= 1'b0;
      dout   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          ack <= 1'b0;
          if (req) begin
            addr_q <= address;
            we_q   <= we;
            din_q  <= din;
            cnt    <= CNT_LOAD;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (!we_q) begin
              dout <= mem[addr_q];
            end
            ack   <= 1'b1;
            state <= S_RESP;
          end
        end
        S_RESP: begin
          ack   <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          ack   <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ar_mem_responder.sv
`default_nettype none
// tb_ar_mem_responder: directed self-checking bench; instances with LATENCY 1, 2 and 5 share stimulus.
module tb_ar_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [9:0]  address;
  logic [15:0] din;
  logic        busy1, ack1, busy2, ack2, busy5, ack5;
  logic [15:0] dout1, dout2, dout5;

  int n_cmp = 0;
  int n_err = 0;

  ar_mem_responder #(.ADDR_W(10), .DATA_W(16), .LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .address(address), .din(din),
    .busy(busy2), .ack(ack2), .dout(dout2)
  );

  ar_mem_responder #(.ADDR_W(10), .DATA_W(16), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .address(address), .din(din),
    .busy(busy1), .ack(ack1), .dout(dout1)
  );

  ar_mem_responder #(.ADDR_W(10), .DATA_W(16), .LATENCY(5)) dut_l5 (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .address(address), .din(din),
    .busy(busy5), .ack(ack5), .dout(dout5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One transaction on the LATENCY=2 instance; returns dout seen with ack.
  task automatic do_op(input string tag, input logic w, input logic [9:0] a,
                       input logic [15:0] d, output logic [15:0] rd);
    bit got_ack;
    req = 1'b1; we = w; address = a; din = d;
    tick();
    req = 1'b0; we = 1'b0;
    got_ack = 1'b0;
    rd = 16'h0;
    for (int i = 0; i < 32 && !got_ack; i++) begin
      tick();
      if (ack2) begin
        got_ack = 1'b1;
        rd = dout2;
      end
    end
    if (!got_ack) check({tag, "_ack_timeout"}, 32'd0, 32'd1);
    tick();
    check({tag, "_busy_after"}, {31'd0, busy2}, 32'd0);
    settle(5);
  endtask

  logic [15:0] rd;
  logic [3:0]  lat_vec;
  logic [19:0] b2b_obs, b2b_exp;
  int          acks, adjacent;
  logic        prev_ack;

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; address = '0; din = '0;
    #2;
    check("reset_busy", {31'd0, busy2}, 32'd0);
    check("reset_ack", {31'd0, ack2}, 32'd0);
    check("reset_dout", {16'd0, dout2}, 32'd0);
    settle(2);
    rst_n = 1'b1;
    settle(2);

    // Write then read back
    do_op("wr006", 1'b1, 10'h006, 16'hBEEF, rd);
    do_op("rd006", 1'b0, 10'h006, 16'h0000, rd);
    check("rd006_data", {16'd0, rd}, 32'h0000_BEEF);

    // Latency: per cycle {ack1, ack2, ack5, busy2}
    req = 1'b1; we = 1'b0; address = 10'h006;
    tick();
    req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      lat_vec = {ack1, ack2, ack5, busy2};
      check($sformatf("latency_c%0d", k), {28'd0, lat_vec},
            {28'd0, (k == 1), (k == 2), (k == 5), (k <= 2)});
    end
    settle(4);

    // Boundaries
    do_op("wr000", 1'b1, 10'h000, 16'hA5A5, rd);
    do_op("wr3ff", 1'b1, 10'h3FF, 16'h5A5A, rd);
    do_op("rd000", 1'b0, 10'h000, 16'h0000, rd);
    check("rd000_data", {16'd0, rd}, 32'h0000_A5A5);
    do_op("rd3ff", 1'b0, 10'h3FF, 16'h0000, rd);
    check("rd3ff_data", {16'd0, rd}, 32'h0000_5A5A);

    // Inputs changed while busy must not affect the in-flight read
    do_op("wr001", 1'b1, 10'h001, 16'h0BAD, rd);
    req = 1'b1; we = 1'b0; address = 10'h001; din = 16'h0000;
    tick();
    req = 1'b0; address = 10'h3FF; we = 1'b1; din = 16'h1234;
    acks = 0; rd = 16'h0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (ack2) begin
        acks++;
        rd = dout2;
      end
    end
    we = 1'b0; address = '0; din = '0;
    check("ignore_acks", acks, 32'd1);
    check("ignore_data", {16'd0, rd}, 32'h0000_0BAD);
    settle(4);
    do_op("rd3ff_again", 1'b0, 10'h3FF, 16'h0000, rd);
    check("rd3ff_unchanged", {16'd0, rd}, 32'h0000_5A5A);

    // Back-to-back: req held for 20 edges, acks after edges 2, 6, 10, 14, 18
    req = 1'b1; we = 1'b0; address = 10'h006;
    acks = 0; adjacent = 0; prev_ack = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      b2b_obs[k] = ack2;
      b2b_exp[k] = ((k % 4) == 2);
      if (ack2) acks++;
      if (ack2 && prev_ack) adjacent++;
      prev_ack = ack2;
    end
    req = 1'b0;
    check("b2b_pattern", {12'd0, b2b_obs}, {12'd0, b2b_exp});
    check("b2b_count", acks, 32'd5);
    check("b2b_adjacent", adjacent, 32'd0);
    settle(10);

    // Reset in WAIT discards a pending write
    do_op("wr020", 1'b1, 10'h020, 16'h0001, rd);
    do_op("rd006_pre", 1'b0, 10'h006, 16'h0000, rd);
    check("dout_before_rst", {16'd0, dout2}, 32'h0000_BEEF);
    req = 1'b1; we = 1'b1; address = 10'h020; din = 16'hFFFF;
    tick();
    req = 1'b0; we = 1'b0;
    check("midwr_busy", {31'd0, busy2}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midwr_dout_zero", {16'd0, dout2}, 32'd0);
    check("midwr_busy_rst", {31'd0, busy2}, 32'd0);
    acks = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (ack2) acks++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (ack2) acks++;
    end
    check("midwr_no_ack", acks, 32'd0);
    do_op("rd020", 1'b0, 10'h020, 16'h0000, rd);
    check("rd020_data", {16'd0, rd}, 32'h0000_0001);

    // Reset during RESP: ack clears at once, write already done stays
    req = 1'b1; we = 1'b1; address = 10'h040; din = 16'hC3C3;
    tick();
    req = 1'b0; we = 1'b0;
    acks = 0;
    for (int k = 0; k < 8 && acks == 0; k++) begin
      tick();
      if (ack2) acks++;
    end
    check("resp_ack_seen", acks, 32'd1);
    rst_n = 1'b0;
    #1;
    check("resp_rst_ack", {31'd0, ack2}, 32'd0);
    tick();
    rst_n = 1'b1;
    settle(2);
    do_op("rd040", 1'b0, 10'h040, 16'h0000, rd);
    check("rd040_data", {16'd0, rd}, 32'h0000_C3C3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/ar_mem_responder.md
Name: ar_mem_responder

Overview:
- Memory-side responder on the address bus driven by the address register.
- Accepts a request with a 10-bit address (plus write flag and data), waits a fixed number of wait-state cycles, then performs the read or write on an internal word array.
- Completion is signalled with a one-cycle acknowledge.
- Sits between the address/data registers and the control unit. The control unit holds off the next fetch until `ack` is asserted.

Parameters:
- ADDR_W, 10, address width; array depth is 2**ADDR_W words.
- DATA_W, 16, data word width.
- LATENCY, 2, wait-state cycles between acceptance and response; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  1  request strobe; sampled only while idle.
- we  input  1  1 = write, 0 = read; sampled with req.
- address  input  ADDR_W  word address from the address register; sampled with req.
- din  input  DATA_W  write data; sampled with req.
- busy  output  1  high from the acceptance edge until the return to IDLE.
- ack  output  1  one-cycle completion pulse.
- dout  output  DATA_W  read data; valid while ack is high, held until the next read completes.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, busy=0, ack=0, dout=0, wait counter=0.
  - Latched address, we and data are cleared.
  - Array contents are NOT reset.
- State register: IDLE, WAIT, RESP.
- IDLE:
  - On a rising edge with req=1: latch address, we and din; load counter with LATENCY-1; go to WAIT.
  - With req=0: stay in IDLE.
  - This rising edge is the acceptance edge E0.
- WAIT:
  - Each rising edge with counter>0 decrements the counter.
  - On the rising edge with counter==0, go to RESP and perform the access on that same edge:
    - write: mem[latched address] <= latched din; dout unchanged.
    - read: dout <= mem[latched address].
  - ack <= 1 on that edge.
  - As a result, ack is high during the cycle after edge E0+LATENCY.
- RESP:
  - Next rising edge: ack <= 0, go to IDLE unconditionally.
  - A req held high through RESP is not accepted here. It is accepted on the first edge in IDLE.
  - Minimum request-to-request spacing is therefore LATENCY+2 cycles.
- busy is decoded combinationally: high when state is WAIT or RESP.
- Changes to req, we, address or din while busy=1 are ignored and have no effect on the in-flight access.
- ack is never high for two consecutive cycles.
- ack and busy are both high during the RESP cycle.
- Address arithmetic:
  - Full ADDR_W decode; no out-of-range condition exists.
  - Addresses 0 and 2**ADDR_W-1 are both valid.
- Read-after-write to the same address in the next transaction returns the newly written data.
- Reset mid-operation:
  - Asserting rst_n in WAIT returns to IDLE immediately.
  - The pending write is discarded and the array is unmodified.
  - The pending read is discarded and dout goes to 0.
  - No ack is produced.
- Reset during RESP clears ack immediately; a write already performed on the RESP-entry edge remains in the array.
- Elaboration must flag LATENCY outside the range 1..15 as an error.

Test Plan:
- Reset then write/read: rst_n low then high; write address=10'h006, din=16'hBEEF; then read address=10'h006 → second ack has dout=16'hBEEF, busy=0 after each RESP.
- Latency check with LATENCY=2: req=1 accepted at edge E0 → ack=1 only in the cycle after E2, busy high from E0 to E3, ack low otherwise. Repeat with LATENCY=1 and LATENCY=5 (ack after E1 and after E5 respectively).
- Ignore while busy: after acceptance at address 10'h001, change address to 10'h3FF, set we=1 and din=16'h1234 during WAIT → read of 10'h001 completes, mem[10'h3FF] unchanged, only one ack.
- Boundaries: write 16'hA5A5 to 10'h000 and 16'h5A5A to 10'h3FF, then read both → correct data returned, no aliasing.
- Back-to-back: req held high for 20 cycles with we=0 and LATENCY=2 → ack pulses exactly every 4 cycles, never two ack cycles adjacent.
- Reset mid-write: write 16'hFFFF to 10'h020 (previous contents 16'h0001); pull rst_n low in WAIT, release, then read 10'h020 → returns 16'h0001; no ack during the reset sequence; dout=0 immediately on reset.
